// File: rtl/reg_write_port_pkg.sv
// rtl/reg_write_port_pkg.sv - shared sizes, stack-pointer init value and state encoding
package reg_write_port_pkg;
    localparam int          DEF_WIDTH   = 32;
    localparam int          DEF_SIZE    = 5;
    localparam int          NUM_REGS    = 32;
    localparam int          IDX_W       = 5;
    localparam int          SP_IDX      = 29;
    localparam logic [31:0] DEF_SP_INIT = 32'h1001_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/reg_write_port_dec_bits.sv
// rtl/reg_write_port_dec_bits.sv - address to one-hot register write-enable decoder
module DEC_bits
    import reg_write_port_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0]     addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i && addr_i == SIZE'(i)) onehot_o[i] = 1'b1;
        end
    end
endmodule

// File: rtl/reg_write_port.sv
// rtl/reg_write_port.sv - register file write port with 2-deep write queue and clear sweep
module reg_write_port
    import reg_write_port_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               SIZE    = DEF_SIZE,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(DEF_SP_INIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             wr_commit,
    output logic [1:0]       fifo_level,
    output logic [WIDTH-1:0] q_0,  q_1,  q_2,  q_3,  q_4,  q_5,  q_6,  q_7,
    output logic [WIDTH-1:0] q_8,  q_9,  q_10, q_11, q_12, q_13, q_14, q_15,
    output logic [WIDTH-1:0] q_16, q_17, q_18, q_19, q_20, q_21, q_22, q_23,
    output logic [WIDTH-1:0] q_24, q_25, q_26, q_27, q_28, q_29, q_30, q_31
);
    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          level_q;
    logic                rd_ptr_q, wr_ptr_q;
    logic                commit_q;
    logic [SIZE-1:0]     fa_q [2];
    logic [WIDTH-1:0]    fd_q [2];
    logic [WIDTH-1:0]    regs_q [NUM_REGS];

    logic                accept, commit, clr_go, dec_en;
    logic [SIZE-1:0]     dec_addr;
    logic [WIDTH-1:0]    wdata;
    logic [NUM_REGS-1:0] we;

    assign wr_ready = reset && state_q == ST_IDLE && level_q != 2'd2;
    assign accept   = wr_valid && wr_ready;
    assign commit   = state_q == ST_IDLE && level_q != 2'd0;
    assign clr_go   = clr_start && state_q == ST_IDLE && level_q == 2'd0;

    // One decoder serves both the queue head and the clear sweep.
    assign dec_en   = state_q == ST_CLEAR || commit;
    assign dec_addr = (state_q == ST_CLEAR) ? SIZE'(idx_q) : fa_q[rd_ptr_q];
    assign wdata    = (state_q == ST_CLEAR)
                    ? ((idx_q == IDX_W'(SP_IDX)) ? SP_INIT : '0)
                    : fd_q[rd_ptr_q];

    DEC_bits #(.SIZE(SIZE)) u_dec (
        .addr_i   (dec_addr),
        .en_i     (dec_en),
        .onehot_o (we)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            fa_q[wr_ptr_q] <= wr_addr;
            fd_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            level_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            commit_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            commit_q <= commit;
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (commit) rd_ptr_q <= ~rd_ptr_q;
            unique case ({accept, commit})
                2'b10:   level_q <= level_q + 2'd1;
                2'b01:   level_q <= level_q - 2'd1;
                default: level_q <= level_q;
            endcase
            // Register 0 is hard-wired to zero even though its write is consumed.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we[i]) regs_q[i] <= (i == 0) ? '0 : wdata;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (clr_go) begin
                        state_q <= ST_CLEAR;
                        idx_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_REGS - 1)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign clr_busy   = state_q == ST_CLEAR;
    assign wr_commit  = commit_q;
    assign fifo_level = level_q;

    assign q_0  = regs_q[0];  assign q_1  = regs_q[1];  assign q_2  = regs_q[2];  assign q_3  = regs_q[3];
    assign q_4  = regs_q[4];  assign q_5  = regs_q[5];  assign q_6  = regs_q[6];  assign q_7  = regs_q[7];
    assign q_8  = regs_q[8];  assign q_9  = regs_q[9];  assign q_10 = regs_q[10]; assign q_11 = regs_q[11];
    assign q_12 = regs_q[12]; assign q_13 = regs_q[13]; assign q_14 = regs_q[14]; assign q_15 = regs_q[15];
    assign q_16 = regs_q[16]; assign q_17 = regs_q[17]; assign q_18 = regs_q[18]; assign q_19 = regs_q[19];
    assign q_20 = regs_q[20]; assign q_21 = regs_q[21]; assign q_22 = regs_q[22]; assign q_23 = regs_q[23];
    assign q_24 = regs_q[24]; assign q_25 = regs_q[25]; assign q_26 = regs_q[26]; assign q_27 = regs_q[27];
    assign q_28 = regs_q[28]; assign q_29 = regs_q[29]; assign q_30 = regs_q[30]; assign q_31 = regs_q[31];
endmodule

// File: tb/tb_reg_write_port.sv
// tb/tb_reg_write_port.sv - self-checking bench for reg_write_port against a queue-based model
module tb_reg_write_port;
    localparam logic [31:0] SP = 32'h1001_0000;

    logic        clk, reset, wr_valid, clr_start;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready, clr_busy, wr_commit;
    logic [1:0]  fifo_level;
    logic [31:0] q_arr [32];

    int errors = 0;
    int checks = 0;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    logic [31:0] m_regs [32];
    ent_t        m_q [$];
    int          m_clr_left;
    bit          m_commit;

    reg_write_port dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start),
        .clr_busy(clr_busy), .wr_commit(wr_commit), .fifo_level(fifo_level),
        .q_0(q_arr[0]),   .q_1(q_arr[1]),   .q_2(q_arr[2]),   .q_3(q_arr[3]),
        .q_4(q_arr[4]),   .q_5(q_arr[5]),   .q_6(q_arr[6]),   .q_7(q_arr[7]),
        .q_8(q_arr[8]),   .q_9(q_arr[9]),   .q_10(q_arr[10]), .q_11(q_arr[11]),
        .q_12(q_arr[12]), .q_13(q_arr[13]), .q_14(q_arr[14]), .q_15(q_arr[15]),
        .q_16(q_arr[16]), .q_17(q_arr[17]), .q_18(q_arr[18]), .q_19(q_arr[19]),
        .q_20(q_arr[20]), .q_21(q_arr[21]), .q_22(q_arr[22]), .q_23(q_arr[23]),
        .q_24(q_arr[24]), .q_25(q_arr[25]), .q_26(q_arr[26]), .q_27(q_arr[27]),
        .q_28(q_arr[28]), .q_29(q_arr[29]), .q_30(q_arr[30]), .q_31(q_arr[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        bit idle;
        int n;
        int ix;
        ent_t e;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? SP : 32'h0;
            m_q.delete();
            m_clr_left = 0;
            m_commit = 0;
            return;
        end
        idle = (m_clr_left == 0);
        n = m_q.size();
        m_commit = 0;
        if (!idle) begin
            ix = 32 - m_clr_left;
            m_regs[ix] = (ix == 29) ? SP : 32'h0;
            m_clr_left--;
        end else if (n > 0) begin
            e = m_q.pop_front();
            if (e.a != 0) m_regs[e.a] = e.d;
            m_commit = 1;
        end
        if (wr_valid && idle && n < 2) begin
            e.a = wr_addr;
            e.d = wr_data;
            m_q.push_back(e);
        end
        if (clr_start && idle && n == 0) m_clr_left = 32;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 0; wr_valid = 0; clr_start = 0; wr_addr = 0; wr_data = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", wr_ready); end
        end
        reset = 1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b want 1", wr_ready); end
        checks++;
        if (fifo_level !== 2'd0 || clr_busy !== 1'b0 || wr_commit !== 1'b0) begin
            errors++; $display("FAIL reset_flags: level=%0d busy=%b commit=%b want 0/0/0", fifo_level, clr_busy, wr_commit);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (q_arr[i] !== ((i == 29) ? SP : 32'h0)) begin
                errors++; $display("FAIL reset_q%0d: got %h want %h", i, q_arr[i], (i == 29) ? SP : 32'h0);
            end
        end
    endtask

    task automatic test_single_write();
        wr_valid = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_valid = 0;
        checks++;
        if (fifo_level !== 2'd1 || q_arr[5] !== m_regs[5] || wr_commit !== 1'b0) begin
            errors++; $display("FAIL single_accept: level=%0d q5=%h commit=%b want 1/%h/0", fifo_level, q_arr[5], wr_commit, m_regs[5]);
        end
        tick();
        checks++;
        if (q_arr[5] !== 32'hDEAD_BEEF || wr_commit !== 1'b1 || fifo_level !== 2'd0) begin
            errors++; $display("FAIL single_commit: q5=%h commit=%b level=%0d want deadbeef/1/0", q_arr[5], wr_commit, fifo_level);
        end
        tick();
        checks++;
        if (wr_commit !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b want 0", wr_commit); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int cyc = 0;
        wr_valid = 1; wr_addr = 3; wr_data = 1;
        while (k < 3 && cyc < 20) begin
            bit acc;
            acc = wr_ready;
            tick();
            cyc++;
            checks++;
            if (fifo_level > 2 || fifo_level !== 2'(m_q.size())) begin
                errors++; $display("FAIL b2b_level: got %0d want %0d", fifo_level, m_q.size());
            end
            if (acc) begin k++; wr_data = 32'(k + 1); end
        end
        wr_valid = 0;
        checks++;
        if (k != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", k); end
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (q_arr[3] !== 32'd3) begin errors++; $display("FAIL b2b_final: q3=%h want 3", q_arr[3]); end
    endtask

    task automatic test_addr_zero();
        wr_valid = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_valid = 0;
        tick();
        checks++;
        if (wr_commit !== 1'b1 || q_arr[0] !== 32'h0) begin
            errors++; $display("FAIL addr0: commit=%b q0=%h want 1/0", wr_commit, q_arr[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_addr   = 5'($urandom);
            wr_data   = $urandom;
            clr_start = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if (wr_ready !== (m_clr_left == 0 && m_q.size() < 2) || fifo_level !== 2'(m_q.size())
                || wr_commit !== m_commit || clr_busy !== (m_clr_left > 0)) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d: ready=%b level=%0d commit=%b busy=%b want %b/%0d/%b/%b", c,
                         wr_ready, fifo_level, wr_commit, clr_busy, (m_clr_left == 0 && m_q.size() < 2),
                         m_q.size(), m_commit, (m_clr_left > 0));
            end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (q_arr[i] !== m_regs[i]) begin
                    errors++; $display("FAIL rand_q%0d c=%0d: got %h want %h", i, c, q_arr[i], m_regs[i]);
                end
            end
        end
        wr_valid = 0; clr_start = 0;
        while (m_clr_left > 0 || m_q.size() > 0) tick();
    endtask

    task automatic test_clear();
        int cnt = 0;
        for (int i = 1; i < 32; i += 6) begin
            wr_valid = 1; wr_addr = 5'(i); wr_data = $urandom | 32'h1;
            tick();
        end
        wr_valid = 0;
        tick();
        clr_start = 1;
        tick();
        clr_start = 0;
        wr_valid = 1; wr_addr = 7; wr_data = 32'h1234_5678;
        while (clr_busy === 1'b1 && cnt < 40) begin
            checks++;
            if (wr_ready !== 1'b0 || fifo_level !== 2'd0) begin
                errors++; $display("FAIL clear_ready: ready=%b level=%0d want 0/0", wr_ready, fifo_level);
            end
            tick();
            cnt++;
        end
        wr_valid = 0;
        checks++;
        if (cnt != 32) begin errors++; $display("FAIL clear_cycles: got %0d want 32", cnt); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (q_arr[i] !== ((i == 29) ? SP : 32'h0)) begin
                errors++; $display("FAIL clear_q%0d: got %h want %h", i, q_arr[i], (i == 29) ? SP : 32'h0);
            end
        end
        wr_valid = 1; wr_addr = 9; wr_data = 32'hA5A5_0009;
        tick();
        wr_valid = 0; clr_start = 1;
        tick();
        clr_start = 0;
        checks++;
        if (clr_busy !== 1'b0 || q_arr[9] !== 32'hA5A5_0009) begin
            errors++; $display("FAIL clear_ignored: busy=%b q9=%h want 0/a5a50009", clr_busy, q_arr[9]);
        end
        tick();
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_not_latched: got %b want 0", clr_busy); end
    endtask

    task automatic test_reset_mid_clear();
        wr_valid = 1; wr_addr = 12; wr_data = 32'hCAFE_0012;
        tick();
        wr_valid = 0;
        tick();
        clr_start = 1;
        tick();
        clr_start = 0;
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (clr_busy !== 1'b1 || (32 - m_clr_left) != 10) begin
            errors++; $display("FAIL midclear_state: busy=%b idx=%0d want 1/10", clr_busy, 32 - m_clr_left);
        end
        reset = 0;
        tick();
        checks++;
        if (clr_busy !== 1'b0 || fifo_level !== 2'd0 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL midclear_reset: busy=%b level=%0d ready=%b want 0/0/0", clr_busy, fifo_level, wr_ready);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (q_arr[i] !== ((i == 29) ? SP : 32'h0)) begin
                errors++; $display("FAIL midclear_q%0d: got %h want %h", i, q_arr[i], (i == 29) ? SP : 32'h0);
            end
        end
        reset = 1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL midclear_release: got %b want 1", wr_ready); end
        wr_valid = 1; wr_addr = 14; wr_data = 32'h0BAD_0014;
        tick();
        wr_valid = 0; reset = 0;
        tick();
        reset = 1;
        tick();
        checks++;
        if (wr_commit !== 1'b0 || q_arr[14] !== 32'h0 || fifo_level !== 2'd0) begin
            errors++; $display("FAIL reset_discard: commit=%b q14=%h level=%0d want 0/0/0", wr_commit, q_arr[14], fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_addr_zero();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_write_port.md
REG_WRITE_PORT -- requirements
Module: reg_write_port

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter SIZE, default 5, register address width (32 registers).
REQ-003 Parameter SP_INIT, default 32'h1001_0000, value loaded into register 29 ($sp) on reset and clear.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 wr_valid  input  1  write request present.
REQ-007 wr_ready  output  1  port can accept a request this cycle.
REQ-008 wr_addr  input  SIZE  destination register index.
REQ-009 wr_data  input  WIDTH  value to write.
REQ-010 clr_start  input  1  one-cycle request to clear the register file.
REQ-011 clr_busy  output  1  clear sweep in progress.
REQ-012 wr_commit  output  1  one-cycle pulse, a queued write was committed at this edge.
REQ-013 fifo_level  output  2  entries held in write queue (0..2).
REQ-014 q_0 .. q_31  output  WIDTH each  registered contents of registers 0..31, feeding the read-side 32:1 multiplexers.

Function
REQ-015 Two states SHALL exist: IDLE and CLEAR.
REQ-016 Request SHALL be accepted on an edge where wr_valid=1 and wr_ready=1; it enters a 2-entry in-order FIFO.
REQ-017 wr_ready SHALL be 1 only in IDLE with fifo_level<2.
REQ-018 In IDLE with fifo_level>0, the head entry SHALL be committed at each edge: one register written, wr_commit=1 for the following cycle, entry popped.
REQ-019 Latency: request accepted at edge N into an empty FIFO SHALL appear on q_<addr> after edge N+1.
REQ-020 Simultaneous accept and commit at the same edge SHALL leave fifo_level unchanged.
REQ-021 Commits to address 0 SHALL be consumed (wr_commit pulses) but q_0 SHALL remain 0.
REQ-022 Two queued writes to the same address SHALL commit in arrival order; the later value wins.
REQ-023 Only the addressed register SHALL change on a commit; all others hold.
REQ-024 clr_start SHALL be honoured only in IDLE with fifo_level=0; otherwise ignored (not latched).
REQ-025 Honoured clr_start SHALL move to CLEAR next edge with sweep index 0; clr_busy=1 throughout CLEAR.
REQ-026 CLEAR SHALL zero register[index] each edge, loading SP_INIT when index=29, index increments; after index 31 is written state returns to IDLE (exactly 32 cycles with clr_busy=1).
REQ-027 wr_valid during CLEAR SHALL be ignored (wr_ready=0); no data loss since no handshake completes.

Reset
REQ-028 While reset=0 at an edge: state IDLE, FIFO empty, fifo_level=0, wr_commit=0, clr_busy=0, all q_n=0 except q_29=SP_INIT.
REQ-029 wr_ready SHALL be 0 while reset is low and 1 the first cycle after release.
REQ-030 Reset asserted mid-CLEAR or with FIFO entries SHALL abort the sweep and discard queued writes.

Structure
REQ-031 WIDTH, SIZE, register count 32, SP index 29 and SP_INIT SHALL live in a shared package with the state encoding.
REQ-032 A sub-module DEC_bits (SIZE-to-32 one-hot write-enable decoder with enable input) SHALL generate per-register enables.

Verification
REQ-033 Reset release -> q_29=32'h1001_0000, all other q=0, wr_ready=1, fifo_level=0.
REQ-034 Write addr 5 data 32'hDEAD_BEEF accepted at edge N -> q_5=32'hDEAD_BEEF after N+1, wr_commit pulse one cycle.
REQ-035 Back-to-back writes addr 3 =1, =2, =3 with wr_valid held -> fifo_level never exceeds 2, wr_ready drops when full, final q_3=3.
REQ-036 Write addr 0 data 32'hFFFF_FFFF -> wr_commit pulses, q_0 stays 0.
REQ-037 Registers loaded, clr_start in IDLE -> clr_busy high 32 cycles, wr_ready=0, end state q_29=SP_INIT, others 0; clr_start with FIFO nonempty ignored.
REQ-038 reset low at sweep index 10 -> state IDLE, clr_busy=0, all registers at reset values next cycle.
